// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide issue controller: request opcodes,
// one-hot XALU operation codes and FSM state values.
package md_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;
    localparam logic [2:0] OP_MFLO  = 3'd7;

    localparam logic [3:0] XOP_NONE  = 4'b0000;
    localparam logic [3:0] XOP_MULT  = 4'b0001;
    localparam logic [3:0] XOP_MULTU = 4'b0010;
    localparam logic [3:0] XOP_DIV   = 4'b0100;
    localparam logic [3:0] XOP_DIVU  = 4'b1000;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_MOVE  = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;

endpackage

// File: rtl/md_issue_ctrl.sv
// Issue controller between the decode stage and the multiply/divide unit:
// launches MULT/DIV, performs MTHI/MTLO writes and returns MFHI/MFLO results.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int OPW = 3
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic [OPW-1:0]  req_op,
    input  logic [31:0]     rs_data,
    input  logic [31:0]     rt_data,
    output logic            req_ready,
    output logic            stall,
    output logic [3:0]      XALU_OP,
    output logic            HI_WE,
    output logic            LO_WE,
    output logic            XALUOUT_sel,
    output logic [31:0]     A,
    output logic [31:0]     B,
    output logic [31:0]     XALU_Wdata,
    input  logic [31:0]     XALUOUT,
    input  logic            BUSY,
    output logic            mf_valid,
    output logic [31:0]     mf_data
);

    logic [2:0] state;
    logic       accept;

    // Only an idle controller facing an idle unit can take a new request.
    assign req_ready = (state == ST_IDLE) && !BUSY;
    assign stall     = req_valid && !req_ready;
    assign accept    = req_valid && req_ready;

    // Every pulse output defaults low each cycle, so a pulse is exactly one
    // cycle long and a reset mid-operation leaves nothing pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            XALU_OP     <= XOP_NONE;
            HI_WE       <= 1'b0;
            LO_WE       <= 1'b0;
            XALUOUT_sel <= 1'b0;
            A           <= 32'd0;
            B           <= 32'd0;
            XALU_Wdata  <= 32'd0;
            mf_valid    <= 1'b0;
            mf_data     <= 32'd0;
        end else begin
            XALU_OP     <= XOP_NONE;
            HI_WE       <= 1'b0;
            LO_WE       <= 1'b0;
            XALUOUT_sel <= 1'b0;
            mf_valid    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (req_op)
                            OPW'(OP_MULT): begin
                                state   <= ST_ISSUE;
                                XALU_OP <= XOP_MULT;
                                A       <= rs_data;
                                B       <= rt_data;
                            end
                            OPW'(OP_MULTU): begin
                                state   <= ST_ISSUE;
                                XALU_OP <= XOP_MULTU;
                                A       <= rs_data;
                                B       <= rt_data;
                            end
                            OPW'(OP_DIV): begin
                                state   <= ST_ISSUE;
                                XALU_OP <= XOP_DIV;
                                A       <= rs_data;
                                B       <= rt_data;
                            end
                            OPW'(OP_DIVU): begin
                                state   <= ST_ISSUE;
                                XALU_OP <= XOP_DIVU;
                                A       <= rs_data;
                                B       <= rt_data;
                            end
                            OPW'(OP_MTHI): begin
                                state      <= ST_MOVE;
                                HI_WE      <= 1'b1;
                                XALU_Wdata <= rs_data;
                            end
                            OPW'(OP_MTLO): begin
                                state      <= ST_MOVE;
                                LO_WE      <= 1'b1;
                                XALU_Wdata <= rs_data;
                            end
                            OPW'(OP_MFHI): begin
                                state       <= ST_READ;
                                XALUOUT_sel <= 1'b1;
                            end
                            OPW'(OP_MFLO): begin
                                state       <= ST_READ;
                                XALUOUT_sel <= 1'b0;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (!BUSY) begin
                        state <= ST_IDLE;
                    end
                end
                ST_MOVE: state <= ST_IDLE;
                ST_READ: begin
                    // XALUOUT reflects the selector driven during this cycle.
                    mf_data  <= XALUOUT;
                    mf_valid <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed testbench for md_issue_ctrl with a cycle-level occupancy model
// compared against the DUT on every falling edge.
module tb_md_issue_ctrl;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] rs_data, rt_data;
    logic        req_ready, stall;
    logic [3:0]  XALU_OP;
    logic        HI_WE, LO_WE, XALUOUT_sel;
    logic [31:0] A, B, XALU_Wdata;
    logic [31:0] XALUOUT;
    logic        BUSY;
    logic        mf_valid;
    logic [31:0] mf_data;

    int tests = 0;
    int fails = 0;

    md_issue_ctrl #(.OPW(3)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .rs_data(rs_data), .rt_data(rt_data), .req_ready(req_ready), .stall(stall),
        .XALU_OP(XALU_OP), .HI_WE(HI_WE), .LO_WE(LO_WE), .XALUOUT_sel(XALUOUT_sel),
        .A(A), .B(B), .XALU_Wdata(XALU_Wdata), .XALUOUT(XALUOUT), .BUSY(BUSY),
        .mf_valid(mf_valid), .mf_data(mf_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        req_valid = valid;
        req_op    = op;
        rs_data   = rs;
        rt_data   = rt;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Model: after acceptance the block is occupied for one fixed cycle, and
    // a MULT/DIV additionally stays occupied until BUSY is seen low. Pulses
    // scheduled at acceptance appear in the following cycle.
    logic [3:0]  e_xop;
    logic        e_hi, e_lo, e_sel, e_mfv;
    logic [31:0] e_a, e_b, e_wd, e_mfd;
    int          m_left;
    bit          m_waitbusy, m_read_now;
    logic        exp_ready;
    logic        n_mfv;
    logic [31:0] n_mfd;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                e_xop = 4'd0; e_hi = 1'b0; e_lo = 1'b0; e_sel = 1'b0; e_mfv = 1'b0;
                e_a = 32'd0; e_b = 32'd0; e_wd = 32'd0; e_mfd = 32'd0;
                m_left = 0; m_waitbusy = 1'b0; m_read_now = 1'b0;
                checkOutput("rst_xalu_op", XALU_OP, 4'd0);
                checkOutput("rst_we", {HI_WE, LO_WE, XALUOUT_sel, mf_valid}, 4'd0);
                checkOutput("rst_operands", A | B | XALU_Wdata | mf_data, 32'd0);
                checkOutput("rst_ready", req_ready, !BUSY);
            end else begin
                exp_ready = !(m_left > 0 || m_waitbusy) && !BUSY;
                checkOutput("model_ready", req_ready, exp_ready);
                checkOutput("model_stall", stall, req_valid && !exp_ready);
                checkOutput("model_xalu_op", XALU_OP, e_xop);
                checkOutput("model_hi_we", HI_WE, e_hi);
                checkOutput("model_lo_we", LO_WE, e_lo);
                checkOutput("model_sel", XALUOUT_sel, e_sel);
                checkOutput("model_a", A, e_a);
                checkOutput("model_b", B, e_b);
                checkOutput("model_wdata", XALU_Wdata, e_wd);
                checkOutput("model_mf_valid", mf_valid, e_mfv);
                checkOutput("model_mf_data", mf_data, e_mfd);

                n_mfv = 1'b0;
                n_mfd = e_mfd;
                if (m_read_now) begin
                    n_mfv = 1'b1;
                    n_mfd = XALUOUT;
                    m_read_now = 1'b0;
                end
                if (m_left > 0) m_left--;
                else if (m_waitbusy && !BUSY) m_waitbusy = 1'b0;

                e_xop = 4'd0; e_hi = 1'b0; e_lo = 1'b0; e_sel = 1'b0;
                e_mfv = n_mfv; e_mfd = n_mfd;
                if (exp_ready && req_valid) begin
                    m_left = 1;
                    if (req_op < 3'd4) begin
                        e_xop = 4'(1 << req_op);
                        e_a = rs_data;
                        e_b = rt_data;
                        m_waitbusy = 1'b1;
                    end else if (req_op == 3'd4) begin
                        e_hi = 1'b1; e_wd = rs_data;
                    end else if (req_op == 3'd5) begin
                        e_lo = 1'b1; e_wd = rs_data;
                    end else begin
                        e_sel = (req_op == 3'd6);
                        m_read_now = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] timeout");
    end

    int low, xop_cnt, hi_cnt, lo_cnt, overlap, stall_cnt, mfv_cnt, acc_cycle, pulses;
    bit accepted;

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
        XALUOUT = 32'd0;
        BUSY = 1'b0;
        #7;
        checkOutput("init_xalu_op", XALU_OP, 4'd0);
        checkOutput("init_mf_data", mf_data, 32'd0);
        checkOutput("init_ready", req_ready, 1'b1);
        nextCycle();
        nextCycle();
        reset = 1'b0;

        // MULT with BUSY high for five cycles after ISSUE
        nextCycle();
        applyStimulus(1'b1, OP_MULT, 32'h0000_1234, 32'hCABB_FCA8);
        @(negedge clk);
        checkOutput("mult_ready", req_ready, 1'b1);
        nextCycle();
        applyStimulus(1'b0, OP_MULT, 32'hFFFF_FFFF, 32'h0);
        low = 0; xop_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            BUSY = (i >= 2 && i <= 6);
            @(negedge clk);
            if (XALU_OP != 4'd0) xop_cnt++;
            if (i == 1) begin
                checkOutput("mult_xalu_op", XALU_OP, 4'b0001);
                checkOutput("mult_a", A, 32'h0000_1234);
                checkOutput("mult_b", B, 32'hCABB_FCA8);
            end
            if (req_ready) break;
            low++;
            nextCycle();
        end
        checkOutput("mult_ready_low_cycles", low, 7);
        checkOutput("mult_xalu_op_cycles", xop_cnt, 1);
        checkOutput("mult_a_held", A, 32'h0000_1234);

        // MTHI then MTLO back-to-back
        nextCycle();
        applyStimulus(1'b1, OP_MTHI, 32'h0000_1234, 32'h0);
        @(negedge clk);
        checkOutput("mthi_ready", req_ready, 1'b1);
        hi_cnt = 0; lo_cnt = 0; overlap = 0;
        for (int i = 1; i <= 5; i++) begin
            nextCycle();
            if (i == 1) applyStimulus(1'b1, OP_MTLO, 32'h0000_5678, 32'h0);
            if (i == 3) applyStimulus(1'b0, OP_MTLO, 32'h0, 32'h0);
            @(negedge clk);
            if (HI_WE) hi_cnt++;
            if (LO_WE) lo_cnt++;
            if (HI_WE && LO_WE) overlap++;
            if (i == 1) begin
                checkOutput("mthi_we", HI_WE, 1'b1);
                checkOutput("mthi_data", XALU_Wdata, 32'h0000_1234);
                checkOutput("mtlo_stall", stall, 1'b1);
            end
            if (i == 3) begin
                checkOutput("mtlo_we", LO_WE, 1'b1);
                checkOutput("mtlo_data", XALU_Wdata, 32'h0000_5678);
            end
        end
        checkOutput("mthi_pulses", hi_cnt, 1);
        checkOutput("mtlo_pulses", lo_cnt, 1);
        checkOutput("we_overlap", overlap, 0);

        // MFHI returning 0xDEADBEEF
        nextCycle();
        applyStimulus(1'b1, OP_MFHI, 32'h0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, OP_MFHI, 32'h0, 32'h0);
        XALUOUT = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("mfhi_sel", XALUOUT_sel, 1'b1);
        checkOutput("mfhi_valid_early", mf_valid, 1'b0);
        nextCycle();
        XALUOUT = 32'h0;
        @(negedge clk);
        checkOutput("mfhi_sel_after", XALUOUT_sel, 1'b0);
        checkOutput("mfhi_valid", mf_valid, 1'b1);
        checkOutput("mfhi_data", mf_data, 32'hDEAD_BEEF);
        nextCycle();
        @(negedge clk);
        checkOutput("mfhi_valid_end", mf_valid, 1'b0);
        checkOutput("mfhi_data_hold", mf_data, 32'hDEAD_BEEF);

        // DIVU followed by MFLO held during WAIT
        nextCycle();
        applyStimulus(1'b1, OP_DIVU, 32'd100, 32'd7);
        XALUOUT = 32'h0000_0042;
        accepted = 1'b0; acc_cycle = -1; stall_cnt = 0; mfv_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            nextCycle();
            if (i == 1) applyStimulus(1'b1, OP_MFLO, 32'h0, 32'h0);
            if (accepted && req_valid) applyStimulus(1'b0, OP_MFLO, 32'h0, 32'h0);
            BUSY = (i >= 2 && i <= 11);
            @(negedge clk);
            if (i == 1) checkOutput("divu_xalu_op", XALU_OP, 4'b1000);
            if (mf_valid) mfv_cnt++;
            if (!accepted) begin
                if (stall) stall_cnt++;
                if (req_ready && req_valid) begin
                    accepted = 1'b1;
                    acc_cycle = i;
                end
            end
        end
        checkOutput("mflo_accept_cycle", acc_cycle, 13);
        checkOutput("mflo_stall_cycles", stall_cnt, 12);
        checkOutput("mflo_valid_pulses", mfv_cnt, 1);
        checkOutput("mflo_data", mf_data, 32'h0000_0042);

        // Reset between edges while waiting on the unit
        nextCycle();
        applyStimulus(1'b1, OP_MULT, 32'h11, 32'h22);
        nextCycle();
        applyStimulus(1'b0, OP_MULT, 32'h0, 32'h0);
        nextCycle();
        BUSY = 1'b1;
        nextCycle();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_xalu_op", XALU_OP, 4'd0);
        checkOutput("async_we", {HI_WE, LO_WE, XALUOUT_sel, mf_valid}, 4'd0);
        checkOutput("async_a_b", A | B, 32'd0);
        checkOutput("async_wdata", XALU_Wdata, 32'd0);
        checkOutput("async_mf_data", mf_data, 32'd0);
        BUSY = 1'b0;
        #1;
        checkOutput("async_idle_ready", req_ready, 1'b1);
        nextCycle();
        nextCycle();
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (XALU_OP != 4'd0 || HI_WE || LO_WE || mf_valid) pulses++;
            nextCycle();
        end
        checkOutput("post_reset_pulses", pulses, 0);
        checkOutput("post_reset_ready", req_ready, 1'b1);

        // BUSY high while idle holds off a request
        BUSY = 1'b1;
        applyStimulus(1'b1, OP_MTHI, 32'h0000_ABCD, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checkOutput("busy_idle_ready", req_ready, 1'b0);
            checkOutput("busy_idle_stall", stall, 1'b1);
            nextCycle();
        end
        BUSY = 1'b0;
        @(negedge clk);
        checkOutput("busy_release_ready", req_ready, 1'b1);
        checkOutput("busy_release_stall", stall, 1'b0);
        nextCycle();
        applyStimulus(1'b0, OP_MTHI, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("busy_release_hi_we", HI_WE, 1'b1);
        checkOutput("busy_release_wdata", XALU_Wdata, 32'h0000_ABCD);
        nextCycle();
        @(negedge clk);
        checkOutput("busy_release_hi_we_end", HI_WE, 1'b0);

        nextCycle();
        nextCycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 SHALL have parameter OPW, default 3, the width of the request opcode.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  in  1  decode stage presents a mult/div/HI/LO request.
REQ-005 SHALL have port req_op  in  OPW  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
REQ-006 SHALL have ports rs_data, rt_data  in  32 each  source operands.
REQ-007 SHALL have port req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-008 SHALL have port stall  out  1  equals req_valid AND NOT req_ready.
REQ-009 SHALL have ports XALU_OP  out  4,  HI_WE  out  1,  LO_WE  out  1,  XALUOUT_sel  out  1,  A  out  32,  B  out  32,  XALU_Wdata  out  32; these drive the multiply/divide unit.
REQ-010 SHALL have ports XALUOUT  in  32 and BUSY  in  1, returned by the multiply/divide unit.
REQ-011 SHALL have ports mf_valid  out  1 and mf_data  out  32, carrying the MFHI/MFLO result to writeback.

Function
REQ-012 SHALL implement the FSM states IDLE, ISSUE, WAIT, MOVE, READ.
REQ-013 SHALL drive req_ready high only in IDLE with BUSY low.
REQ-014 On acceptance SHALL register req_op, rs_data and rt_data; later changes to the inputs SHALL have no effect.
REQ-015 On accepting ops 0-3, SHALL go IDLE->ISSUE and drive, in ISSUE only, XALU_OP one-hot (MULT 4'b0001, MULTU 4'b0010, DIV 4'b0100, DIVU 4'b1000), with A=rs and B=rt.
REQ-016 ISSUE SHALL last exactly one cycle, then go to WAIT.
REQ-017 In WAIT the block SHALL stay while BUSY is high and return to IDLE in the first cycle BUSY is sampled low.
REQ-018 Outside ISSUE, XALU_OP SHALL be 4'b0000.
REQ-019 On accepting op 4 or 5, SHALL go IDLE->MOVE and, for exactly one cycle, assert HI_WE (MTHI) or LO_WE (MTLO) with XALU_Wdata=rs, then go to IDLE.
REQ-020 HI_WE and LO_WE SHALL never be high together.
REQ-021 On accepting op 6 or 7, SHALL go IDLE->READ and drive XALUOUT_sel (1=HI, 0=LO) for that cycle.
REQ-022 In READ the block SHALL capture XALUOUT into mf_data, pulse mf_valid on the following cycle, and return to IDLE.
REQ-023 mf_data SHALL hold its value until the next MF capture.
REQ-024 A request arriving while not in IDLE or while BUSY is high SHALL be held off (stall high) and never dropped or duplicated.
REQ-025 Turnaround: from a MOVE or READ request to the next acceptance SHALL be exactly 2 cycles; from MULT/DIV, ISSUE plus WAIT plus 1 cycle.
REQ-026 All outputs except req_ready and stall SHALL be registered.

Reset
REQ-027 Reset SHALL force state IDLE, XALU_OP=0, HI_WE=LO_WE=0, XALUOUT_sel=0, A=B=XALU_Wdata=0, mf_valid=0 and mf_data=0, immediately and regardless of the clock.
REQ-028 Reset asserted mid-ISSUE, WAIT, MOVE or READ SHALL abort the operation without any further write-enable, XALU_OP or mf_valid pulse.

Structure
REQ-029 The opcode encodings, the XALU_OP one-hot constants and the FSM state encoding SHALL reside in a shared package, md_pkg.
REQ-030 The block SHALL be a single module with no sub-modules.

Verification
REQ-031 MULT rs=0x1234, rt=0xCABBFCA8 with BUSY high for 5 cycles starting the cycle after ISSUE -> XALU_OP=4'b0001 for exactly 1 cycle, req_ready low for 7 cycles, then high.
REQ-032 MTHI rs=0x1234, then MTLO rs=0x5678 back-to-back -> one HI_WE pulse with data 0x1234, then 2 cycles later one LO_WE pulse with data 0x5678, and never overlapping.
REQ-033 MFHI with XALUOUT=0xDEADBEEF in READ -> XALUOUT_sel=1 for 1 cycle, then mf_valid=1 for 1 cycle with mf_data=0xDEADBEEF.
REQ-034 DIVU issued, then MFLO held valid during WAIT (BUSY high 10 cycles) -> stall high throughout, MFLO accepted on the first IDLE cycle, with a single mf_valid.
REQ-035 Reset asserted in WAIT, between clock edges -> all outputs zero immediately, state IDLE, and no stray pulses after release.
REQ-036 BUSY held high in IDLE with req_valid=1 -> req_ready=0, stall=1, and acceptance on the first cycle BUSY is low.
